rv64_csr_unit: RTL and testbench

- Machine-mode CSR unit, next generation of the current CSR register file.
- Adds CSR read-modify-write ops (RW/RS/RC), hardware trap-entry and mret sequencing of mstatus, free-running mcycle/minstret counters, and registered interrupt-pending generation.
- Sits beside the execute/writeback stage: the pipeline issues CSR instructions and trap/mret events here and receives the trap vector, mepc and the interrupt request.

---
 rtl/rv64_csr_unit.sv | 190 +++++++++++++++++++
 tb/tb_rv64_csr_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/rv64_csr_unit.sv
// rv64_csr_unit: machine-mode CSR file with RW/RS/RC ops, trap/mret sequencing and irq generation.
// Define CSR_COUNTERS_EN to build the mcycle/minstret counters at 0xB00/0xB02.
module rv64_csr_unit #(
    parameter int unsigned         XLEN          = 64,
    parameter logic [XLEN-1:0]     MSTATUS_RESET = 64'h0000_000a_0000_1800,
    parameter logic [XLEN-1:0]     MTVEC_RESET   = 64'h0,
    parameter int unsigned         HARTID        = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            csr_valid_i,
    input  logic [11:0]     csr_addr_i,
    input  logic [1:0]      csr_op_i,
    input  logic [XLEN-1:0] csr_wdata_i,
    output logic [XLEN-1:0] csr_rdata_o,
    output logic            csr_illegal_o,
    input  logic            trap_valid_i,
    input  logic [XLEN-1:0] trap_cause_i,
    input  logic [XLEN-1:0] trap_pc_i,
    input  logic [XLEN-1:0] trap_tval_i,
    input  logic            mret_valid_i,
    input  logic            instret_i,
    input  logic            irq_soft_i,
    input  logic            irq_timer_i,
    input  logic            irq_ext_i,
    output logic [XLEN-1:0] trap_vector_o,
    output logic [XLEN-1:0] mepc_o,
    output logic            irq_pending_o
);

    localparam logic [XLEN-1:0] MISA_VAL   = {2'b10, {(XLEN-15){1'b0}}, 13'h1100};
    localparam logic [XLEN-1:0] HARTID_VAL = XLEN'(HARTID);
    localparam logic [XLEN-1:0] MIE_MASK   = XLEN'(12'h888);
    localparam int unsigned     ST_MIE     = 3;
    localparam int unsigned     ST_MPIE    = 7;

    logic [XLEN-1:0] mstatus_q, mstatus_d;
    logic [XLEN-1:0] mie_q, mie_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mscratch_q, mscratch_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic [XLEN-1:0] mtval_q, mtval_d;
    logic [XLEN-1:0] mip_q, mip_d;
    logic            irq_pending_q, irq_pending_d;
`ifdef CSR_COUNTERS_EN
    logic [XLEN-1:0] mcycle_q, mcycle_d;
    logic [XLEN-1:0] minstret_q, minstret_d;
`else
    logic            unused_instret;
    assign unused_instret = instret_i;
`endif

    logic [XLEN-1:0] rdata;
    logic [XLEN-1:0] wval;
    logic            mapped;
    logic            ro;
    logic            illegal;
    logic            wr_en;

    always_comb begin
        rdata  = '0;
        mapped = 1'b1;
        ro     = 1'b0;
        case (csr_addr_i)
            12'h300: rdata = mstatus_q;
            12'h301: begin rdata = MISA_VAL; ro = 1'b1; end
            12'h304: rdata = mie_q;
            12'h305: rdata = mtvec_q;
            12'h340: rdata = mscratch_q;
            12'h341: rdata = mepc_q;
            12'h342: rdata = mcause_q;
            12'h343: rdata = mtval_q;
            12'h344: rdata = mip_q;
`ifdef CSR_COUNTERS_EN
            12'hB00: rdata = mcycle_q;
            12'hB02: rdata = minstret_q;
`endif
            12'hF14: begin rdata = HARTID_VAL; ro = 1'b1; end
            default: mapped = 1'b0;
        endcase
    end

    always_comb begin
        case (csr_op_i)
            2'b01:   wval = csr_wdata_i;
            2'b10:   wval = rdata | csr_wdata_i;
            2'b11:   wval = rdata & ~csr_wdata_i;
            default: wval = rdata;
        endcase
    end

    // Set/clear with a zero operand is a pure read, so it stays legal on read-only CSRs.
    assign illegal = csr_valid_i && (!mapped ||
                     (ro && ((csr_op_i == 2'b01) ||
                             ((csr_op_i != 2'b00) && (csr_wdata_i != '0)))));
    assign wr_en   = csr_valid_i && (csr_op_i != 2'b00) && !trap_valid_i && !illegal && !ro;

    always_comb begin
        mstatus_d  = mstatus_q;
        mie_d      = mie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        mip_d      = '0;
        mip_d[3]   = irq_soft_i;
        mip_d[7]   = irq_timer_i;
        mip_d[11]  = irq_ext_i;
        if (trap_valid_i) begin
            mstatus_d[ST_MPIE] = mstatus_q[ST_MIE];
            mstatus_d[ST_MIE]  = 1'b0;
            mepc_d             = {trap_pc_i[XLEN-1:2], 2'b00};
            mcause_d           = trap_cause_i;
            mtval_d            = trap_tval_i;
        end else begin
            if (mret_valid_i) begin
                mstatus_d[ST_MIE]  = mstatus_q[ST_MPIE];
                mstatus_d[ST_MPIE] = 1'b1;
            end
            if (wr_en) begin
                case (csr_addr_i)
                    12'h300: if (!mret_valid_i) mstatus_d = wval;
                    12'h304: mie_d      = wval & MIE_MASK;
                    12'h305: mtvec_d    = {wval[XLEN-1:2], 1'b0, wval[0]};
                    12'h340: mscratch_d = wval;
                    12'h341: mepc_d     = {wval[XLEN-1:2], 2'b00};
                    12'h342: mcause_d   = wval;
                    12'h343: mtval_d    = wval;
                    default: ;
                endcase
            end
        end
        mstatus_d[12:11] = 2'b11;
        irq_pending_d    = mstatus_q[ST_MIE] & (|(mip_q & mie_q));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mstatus_q     <= MSTATUS_RESET;
            mie_q         <= '0;
            mtvec_q       <= MTVEC_RESET;
            mscratch_q    <= '0;
            mepc_q        <= '0;
            mcause_q      <= '0;
            mtval_q       <= '0;
            mip_q         <= '0;
            irq_pending_q <= 1'b0;
        end else begin
            mstatus_q     <= mstatus_d;
            mie_q         <= mie_d;
            mtvec_q       <= mtvec_d;
            mscratch_q    <= mscratch_d;
            mepc_q        <= mepc_d;
            mcause_q      <= mcause_d;
            mtval_q       <= mtval_d;
            mip_q         <= mip_d;
            irq_pending_q <= irq_pending_d;
        end
    end

`ifdef CSR_COUNTERS_EN
    always_comb begin
        mcycle_d   = mcycle_q + XLEN'(1);
        minstret_d = instret_i ? minstret_q + XLEN'(1) : minstret_q;
        if (wr_en && (csr_addr_i == 12'hB00)) mcycle_d   = wval;
        if (wr_en && (csr_addr_i == 12'hB02)) minstret_d = wval;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end
`endif

    assign csr_rdata_o   = rdata;
    assign csr_illegal_o = illegal;
    assign mepc_o        = mepc_q;
    assign irq_pending_o = irq_pending_q;
    assign trap_vector_o = (mtvec_q[0] && trap_cause_i[XLEN-1])
                         ? {mtvec_q[XLEN-1:2], 2'b00} + {trap_cause_i[XLEN-3:0], 2'b00}
                         : {mtvec_q[XLEN-1:2], 2'b00};

endmodule

// File: tb/tb_rv64_csr_unit.sv
// Directed bench for rv64_csr_unit: table of single-cycle CSR accesses plus trap/irq/reset/counter sequences.
module tb_rv64_csr_unit;

    localparam logic [63:0] MST_RST = 64'h0000_000a_0000_1800;
    localparam logic [63:0] MISA    = 64'h8000_0000_0000_1100;

    logic        clk, rst;
    logic        csr_valid_i;
    logic [11:0] csr_addr_i;
    logic [1:0]  csr_op_i;
    logic [63:0] csr_wdata_i, csr_rdata_o;
    logic        csr_illegal_o;
    logic        trap_valid_i;
    logic [63:0] trap_cause_i, trap_pc_i, trap_tval_i;
    logic        mret_valid_i, instret_i;
    logic        irq_soft_i, irq_timer_i, irq_ext_i;
    logic [63:0] trap_vector_o, mepc_o;
    logic        irq_pending_o;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    rv64_csr_unit dut (
        .clk(clk), .rst(rst),
        .csr_valid_i(csr_valid_i), .csr_addr_i(csr_addr_i), .csr_op_i(csr_op_i),
        .csr_wdata_i(csr_wdata_i), .csr_rdata_o(csr_rdata_o), .csr_illegal_o(csr_illegal_o),
        .trap_valid_i(trap_valid_i), .trap_cause_i(trap_cause_i), .trap_pc_i(trap_pc_i),
        .trap_tval_i(trap_tval_i), .mret_valid_i(mret_valid_i), .instret_i(instret_i),
        .irq_soft_i(irq_soft_i), .irq_timer_i(irq_timer_i), .irq_ext_i(irq_ext_i),
        .trap_vector_o(trap_vector_o), .mepc_o(mepc_o), .irq_pending_o(irq_pending_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [11:0] addr;
        logic [1:0]  op;
        logic [63:0] wdata;
        logic [63:0] exp_rd;
        logic        exp_ill;
    } vec_t;

    vec_t vec [25];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    endtask

    task automatic csr(input logic v, input logic [11:0] a, input logic [1:0] op, input logic [63:0] wd);
        csr_valid_i = v;
        csr_addr_i  = a;
        csr_op_i    = op;
        csr_wdata_i = wd;
    endtask

    initial begin
        rst = 1'b0;
        csr(1'b0, 12'h000, 2'b00, 64'h0);
        trap_valid_i = 1'b0; trap_cause_i = '0; trap_pc_i = '0; trap_tval_i = '0;
        mret_valid_i = 1'b0; instret_i = 1'b0;
        irq_soft_i = 1'b0; irq_timer_i = 1'b0; irq_ext_i = 1'b0;

        vec[0]  = '{1'b1, 12'h300, 2'b00, 64'h0,         MST_RST,       1'b0};
        vec[1]  = '{1'b1, 12'h340, 2'b01, 64'hDEAD_BEEF, 64'h0,         1'b0};
        vec[2]  = '{1'b1, 12'h340, 2'b10, 64'hF0,        64'hDEAD_BEEF, 1'b0};
        vec[3]  = '{1'b1, 12'h340, 2'b11, 64'h0F,        64'hDEAD_BEFF, 1'b0};
        vec[4]  = '{1'b1, 12'h340, 2'b00, 64'h0,         64'hDEAD_BEF0, 1'b0};
        vec[5]  = '{1'b1, 12'h301, 2'b01, 64'h5,         MISA,          1'b1};
        vec[6]  = '{1'b1, 12'h301, 2'b00, 64'h0,         MISA,          1'b0};
        vec[7]  = '{1'b1, 12'hF14, 2'b10, 64'h0,         64'h0,         1'b0};
        vec[8]  = '{1'b1, 12'hF14, 2'b11, 64'h1,         64'h0,         1'b1};
        vec[9]  = '{1'b1, 12'h7C0, 2'b00, 64'h0,         64'h0,         1'b1};
        vec[10] = '{1'b0, 12'h7C0, 2'b00, 64'h0,         64'h0,         1'b0};
        vec[11] = '{1'b1, 12'h341, 2'b01, 64'h1237,      64'h0,         1'b0};
        vec[12] = '{1'b1, 12'h341, 2'b00, 64'h0,         64'h1234,      1'b0};
        vec[13] = '{1'b1, 12'h305, 2'b01, 64'h8000_0003, 64'h0,         1'b0};
        vec[14] = '{1'b1, 12'h305, 2'b00, 64'h0,         64'h8000_0001, 1'b0};
        vec[15] = '{1'b1, 12'h304, 2'b01, 64'hFFFF,      64'h0,         1'b0};
        vec[16] = '{1'b1, 12'h304, 2'b00, 64'h0,         64'h888,       1'b0};
        vec[17] = '{1'b1, 12'h344, 2'b01, 64'hFFFF,      64'h0,         1'b0};
        vec[18] = '{1'b1, 12'h344, 2'b00, 64'h0,         64'h0,         1'b0};
        vec[19] = '{1'b1, 12'h300, 2'b01, 64'h0,         MST_RST,       1'b0};
        vec[20] = '{1'b1, 12'h300, 2'b00, 64'h0,         64'h1800,      1'b0};
        vec[21] = '{1'b1, 12'h342, 2'b01, 64'h55,        64'h0,         1'b0};
        vec[22] = '{1'b1, 12'h342, 2'b00, 64'h0,         64'h55,        1'b0};
        vec[23] = '{1'b1, 12'h343, 2'b01, 64'h66,        64'h0,         1'b0};
        vec[24] = '{1'b1, 12'h343, 2'b00, 64'h0,         64'h66,        1'b0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_irq_pending", 64'(irq_pending_o), 64'h0);
        check("rst_mepc", mepc_o, 64'h0);
        rst = 1'b1;

        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            csr(vec[i].valid, vec[i].addr, vec[i].op, vec[i].wdata);
            #1;
            check($sformatf("vec%0d_rdata", i), csr_rdata_o, vec[i].exp_rd);
            check($sformatf("vec%0d_illegal", i), 64'(csr_illegal_o), 64'(vec[i].exp_ill));
        end

        // Trap entry with a squashed same-cycle write, then mret.
        @(negedge clk); csr(1'b1, 12'h300, 2'b10, 64'h8);
        @(negedge clk); csr(1'b1, 12'h300, 2'b00, 64'h0); #1;
        check("mie_set", csr_rdata_o, 64'h1808);
        @(negedge clk);
        csr(1'b1, 12'h340, 2'b01, 64'h1111);
        trap_valid_i = 1'b1; trap_cause_i = 64'h2; trap_pc_i = 64'h8000_0006; trap_tval_i = 64'h13;
        #1;
        check("trap_vec_exc", trap_vector_o, 64'h8000_0000);
        check("trap_cycle_rdata", csr_rdata_o, 64'hDEAD_BEF0);
        @(negedge clk);
        trap_valid_i = 1'b0; csr(1'b1, 12'h340, 2'b00, 64'h0); #1;
        check("trap_squash_mscratch", csr_rdata_o, 64'hDEAD_BEF0);
        check("trap_mepc", mepc_o, 64'h8000_0004);
        @(negedge clk); csr(1'b1, 12'h342, 2'b00, 64'h0); #1;
        check("trap_mcause", csr_rdata_o, 64'h2);
        @(negedge clk); csr(1'b1, 12'h343, 2'b00, 64'h0); #1;
        check("trap_mtval", csr_rdata_o, 64'h13);
        @(negedge clk); csr(1'b1, 12'h300, 2'b00, 64'h0); mret_valid_i = 1'b1; #1;
        check("trap_mstatus", csr_rdata_o, 64'h1880);
        @(negedge clk); mret_valid_i = 1'b0; #1;
        check("mret_mstatus", csr_rdata_o, 64'h1888);

        // Vectored vs direct trap target.
        @(negedge clk); csr(1'b0, 12'h000, 2'b00, 64'h0);
        trap_cause_i = 64'h8000_0000_0000_0007; #1;
        check("vec_irq7", trap_vector_o, 64'h8000_001C);
        @(negedge clk); trap_cause_i = 64'h5; #1;
        check("vec_exc5", trap_vector_o, 64'h8000_0000);
        @(negedge clk); csr(1'b1, 12'h305, 2'b01, 64'h4000);
        @(negedge clk); csr(1'b0, 12'h000, 2'b00, 64'h0);
        trap_cause_i = 64'h8000_0000_0000_0007; #1;
        check("vec_direct_irq", trap_vector_o, 64'h4000);

        // Timer pulse: mip one cycle later, irq_pending one cycle after that.
        @(negedge clk); irq_timer_i = 1'b1; #1;
        check("irq_idle", 64'(irq_pending_o), 64'h0);
        @(negedge clk); irq_timer_i = 1'b0; csr(1'b1, 12'h344, 2'b00, 64'h0); #1;
        check("mip_timer", csr_rdata_o, 64'h80);
        check("irq_lag", 64'(irq_pending_o), 64'h0);
        @(negedge clk); #1;
        check("irq_pending", 64'(irq_pending_o), 64'h1);
        check("mip_cleared", csr_rdata_o, 64'h0);
        @(negedge clk); #1;
        check("irq_drop", 64'(irq_pending_o), 64'h0);

        // Reset overriding a trap and a write in the same cycle.
        @(negedge clk); irq_ext_i = 1'b1;
        @(negedge clk); #1;
        check("irq_ext_lag", 64'(irq_pending_o), 64'h0);
        @(negedge clk); #1;
        check("irq_ext_pending", 64'(irq_pending_o), 64'h1);
        rst = 1'b0;
        csr(1'b1, 12'h340, 2'b01, 64'h77);
        trap_valid_i = 1'b1; trap_cause_i = 64'h3; trap_pc_i = 64'h100; trap_tval_i = 64'h9;
        @(negedge clk);
        rst = 1'b1; trap_valid_i = 1'b0; irq_ext_i = 1'b0;
        csr(1'b1, 12'h340, 2'b00, 64'h0); #1;
        check("rst_mid_pending", 64'(irq_pending_o), 64'h0);
        check("rst_mid_mepc", mepc_o, 64'h0);
        check("rst_mid_mscratch", csr_rdata_o, 64'h0);
        @(negedge clk); csr(1'b1, 12'h300, 2'b00, 64'h0); #1;
        check("rst_mid_mstatus", csr_rdata_o, MST_RST);
        @(negedge clk); csr(1'b1, 12'h342, 2'b00, 64'h0); #1;
        check("rst_mid_mcause", csr_rdata_o, 64'h0);

`ifdef CSR_COUNTERS_EN
        @(negedge clk); csr(1'b1, 12'hB00, 2'b00, 64'h0); #1;
        check("mcycle_after_rst", csr_rdata_o, 64'h3);
        check("mcycle_legal", 64'(csr_illegal_o), 64'h0);
        @(negedge clk); csr(1'b1, 12'hB02, 2'b01, '1); instret_i = 1'b1; #1;
        check("minstret_zero", csr_rdata_o, 64'h0);
        @(negedge clk); csr(1'b1, 12'hB02, 2'b00, 64'h0); #1;
        check("minstret_write_wins", csr_rdata_o, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clk); instret_i = 1'b0; #1;
        check("minstret_wrap", csr_rdata_o, 64'h0);
        @(negedge clk); csr(1'b1, 12'hB00, 2'b01, 64'h5); #1;
        check("mcycle_old", csr_rdata_o, 64'h7);
        @(negedge clk); csr(1'b1, 12'hB00, 2'b00, 64'h0); #1;
        check("mcycle_write_wins", csr_rdata_o, 64'h5);
`else
        @(negedge clk); csr(1'b1, 12'hB00, 2'b00, 64'h0); #1;
        check("mcycle_absent_rdata", csr_rdata_o, 64'h0);
        check("mcycle_absent_illegal", 64'(csr_illegal_o), 64'h1);
        @(negedge clk); csr(1'b1, 12'hB02, 2'b01, '1); instret_i = 1'b1; #1;
        check("minstret_absent_rdata", csr_rdata_o, 64'h0);
        check("minstret_absent_illegal", 64'(csr_illegal_o), 64'h1);
        @(negedge clk); instret_i = 1'b0; csr(1'b1, 12'hB02, 2'b00, 64'h0); #1;
        check("minstret_absent_read", csr_rdata_o, 64'h0);
`endif

        @(negedge clk); csr(1'b0, 12'h000, 2'b00, 64'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
